// File: rtl/dec_queue_pkg.sv
// Shared types for the decoded-instruction queue: operand, immediate,
// unit and command types, the packed per-slot entry, and default sizing.
// No ports; imported by dec_queue and dec_queue_ptr.
package dec_queue_pkg;

    localparam int AddrWidth     = 32;
    localparam int DecQueueDepth = 8;

    typedef logic [4:0]  RegFile_t;
    typedef logic [31:0] ImmData_t;
    typedef logic [3:0]  OpCommand_t;

    typedef enum logic [1:0] {
        UNIT_ALU = 2'd0,
        UNIT_MEM = 2'd1,
        UNIT_BR  = 2'd2,
        UNIT_MUL = 2'd3
    } ExeUnit_t;

    // One queue slot: everything the issue stage needs about a decoded op.
    typedef struct packed {
        logic [AddrWidth-1:0] pc;
        RegFile_t             rs1;
        RegFile_t             rs2;
        RegFile_t             rd;
        logic                 invalid;
        ImmData_t             imm;
        ExeUnit_t             unit;
        OpCommand_t           command;
    } DecQueueEntry_t;

endpackage

// File: rtl/dec_queue_ptr.sv
// Head/tail/occupancy bookkeeping for dec_queue; 0-cycle decode of full/empty/is_full from registered count.
// Latency: pointer/count update visible 1 cycle after the accepting edge.
// Backpressure: push while full is dropped and sets sticky overflow; pop while empty is ignored.
// Ports: clk, reset, flush; push_i/pop_i requests; head_o/tail_o/count_o state;
//        wr_en_o (push actually stored), full_o, empty_o, is_full_o, overflow_o.
module dec_queue_ptr
    import dec_queue_pkg::*;
#(
    parameter int DEPTH = DecQueueDepth,
    parameter int SLACK = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_o,
    output logic [AW-1:0] tail_o,
    output logic [CW-1:0] count_o,
    output logic          wr_en_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          is_full_o,
    output logic          overflow_o
);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push_ok, pop_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign is_full_o = (count_q >= CW'(DEPTH - SLACK));

    // Fullness is judged on the registered count, so a same-cycle pop never
    // makes room for a push.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign wr_en_o = push_ok && !flush && !reset;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (flush) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            // Pointer width is log2(DEPTH), so increments wrap on their own.
            if (push_ok) tail_d = tail_q + AW'(1);
            if (pop_ok)  head_d = head_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
            if (push_i && full_o) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign head_o     = head_q;
    assign tail_o     = tail_q;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/dec_queue.sv
// Decoded-instruction FWFT queue between decoder and issue stage.
// Latency: push visible at head 1 cycle later (0 cycles when built with DEC_QUEUE_BYPASS_EN and empty).
// Backpressure: is_full raised SLACK entries early; pushes beyond DEPTH are dropped and flagged in overflow.
// Ports: clk/reset/flush; dec_e_ (active-low push) + dec_* op fields; is_full;
//        iq_e_ (active-low head valid) + iq_* head fields; issue_ready; count; overflow.
// Optional: define DEC_QUEUE_BYPASS_EN for a combinational dec_* -> iq_* path when empty.
module dec_queue
    import dec_queue_pkg::*;
#(
    parameter int ADDR  = AddrWidth,
    parameter int DEPTH = DecQueueDepth,
    parameter int SLACK = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            dec_e_,
    input  logic [ADDR-1:0] dec_pc,
    input  RegFile_t        dec_rs1,
    input  RegFile_t        dec_rs2,
    input  RegFile_t        dec_rd,
    input  logic            dec_invalid,
    input  ImmData_t        dec_imm,
    input  ExeUnit_t        dec_unit,
    input  OpCommand_t      dec_command,
    output logic            is_full,
    output logic            iq_e_,
    output logic [ADDR-1:0] iq_pc,
    output RegFile_t        iq_rs1,
    output RegFile_t        iq_rs2,
    output RegFile_t        iq_rd,
    output logic            iq_invalid,
    output ImmData_t        iq_imm,
    output ExeUnit_t        iq_unit,
    output OpCommand_t      iq_command,
    input  logic            issue_ready,
    output logic [CW-1:0]   count,
    output logic            overflow
);

    DecQueueEntry_t mem_q [DEPTH];
    DecQueueEntry_t dec_entry;
    DecQueueEntry_t out_entry;
    DecQueueEntry_t head_entry;

    logic [AW-1:0] head, tail;
    logic          wr_en, full, empty;
    logic          push_req, pop_req;
    logic          dec_vld;

    assign dec_vld = !dec_e_;

    always_comb begin
        dec_entry         = '0;
        dec_entry.pc      = dec_pc;
        dec_entry.rs1     = dec_rs1;
        dec_entry.rs2     = dec_rs2;
        dec_entry.rd      = dec_rd;
        dec_entry.invalid = dec_invalid;
        dec_entry.imm     = dec_imm;
        dec_entry.unit    = dec_unit;
        dec_entry.command = dec_command;
    end

    // Head fields read as zero while nothing is queued.
    assign head_entry = empty ? '0 : mem_q[head];
    assign pop_req    = issue_ready && !empty;

`ifdef DEC_QUEUE_BYPASS_EN
    logic byp_vld;

    // An op arriving at an empty queue is presented immediately; if the issue
    // stage takes it this cycle it never touches storage.
    assign byp_vld   = empty && dec_vld && !flush && !reset;
    assign push_req  = dec_vld && !(byp_vld && issue_ready);
    assign out_entry = byp_vld ? dec_entry : head_entry;
    assign iq_e_     = !(byp_vld || !empty);
`else
    assign push_req  = dec_vld;
    assign out_entry = head_entry;
    assign iq_e_     = empty;
`endif

    dec_queue_ptr #(
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .push_i     (push_req),
        .pop_i      (pop_req),
        .head_o     (head),
        .tail_o     (tail),
        .count_o    (count),
        .wr_en_o    (wr_en),
        .full_o     (full),
        .empty_o    (empty),
        .is_full_o  (is_full),
        .overflow_o (overflow)
    );

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[tail] <= dec_entry;
    end

    assign iq_pc      = out_entry.pc;
    assign iq_rs1     = out_entry.rs1;
    assign iq_rs2     = out_entry.rs2;
    assign iq_rd      = out_entry.rd;
    assign iq_invalid = out_entry.invalid;
    assign iq_imm     = out_entry.imm;
    assign iq_unit    = out_entry.unit;
    assign iq_command = out_entry.command;

endmodule

// File: tb/tb_dec_queue.sv
module tb_dec_queue;
    import dec_queue_pkg::*;

    logic        clk = 1'b0;
    logic        reset, flush, dec_e_, dec_invalid, issue_ready;
    logic [31:0] dec_pc;
    RegFile_t    dec_rs1, dec_rs2, dec_rd;
    ImmData_t    dec_imm;
    ExeUnit_t    dec_unit;
    OpCommand_t  dec_command;
    logic        is_full, iq_e_, iq_invalid, overflow;
    logic [31:0] iq_pc;
    RegFile_t    iq_rs1, iq_rs2, iq_rd;
    ImmData_t    iq_imm;
    ExeUnit_t    iq_unit;
    OpCommand_t  iq_command;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dec_queue #(.ADDR(32), .DEPTH(8), .SLACK(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .dec_e_(dec_e_),
        .dec_pc(dec_pc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_invalid(dec_invalid), .dec_imm(dec_imm), .dec_unit(dec_unit),
        .dec_command(dec_command), .is_full(is_full), .iq_e_(iq_e_),
        .iq_pc(iq_pc), .iq_rs1(iq_rs1), .iq_rs2(iq_rs2), .iq_rd(iq_rd),
        .iq_invalid(iq_invalid), .iq_imm(iq_imm), .iq_unit(iq_unit),
        .iq_command(iq_command), .issue_ready(issue_ready), .count(count),
        .overflow(overflow)
    );

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] pc, input logic [4:0] tag);
        dec_e_      = 1'b0;
        dec_pc      = pc;
        dec_rs1     = tag;
        dec_rs2     = tag + 5'd1;
        dec_rd      = tag + 5'd2;
        dec_imm     = {27'd0, tag};
        dec_invalid = tag[0];
        dec_unit    = ExeUnit_t'(tag[1:0]);
        dec_command = tag[3:0];
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
        drive_op(32'h55, 5'd3);
        step(); step();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (iq_e_ !== 1'b1) begin n_fail++; $display("FAIL reset_iq_e got %b exp 1", iq_e_); end
        n_checks++; if (is_full !== 1'b0) begin n_fail++; $display("FAIL reset_is_full got %b exp 0", is_full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        n_checks++; if (iq_pc !== 32'h0) begin n_fail++; $display("FAIL reset_iq_pc got %h exp 0", iq_pc); end
        reset = 1'b0; dec_e_ = 1'b1;
        step();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL post_reset_count got %0d exp 0", count); end
    endtask

    task automatic test_push_pop();
        issue_ready = 1'b0;
        drive_op(32'h100, 5'd4);
        step();
        n_checks++; if (iq_e_ !== 1'b0) begin n_fail++; $display("FAIL pp_first_vld got %b exp 0", iq_e_); end
        n_checks++; if (iq_pc !== 32'h100) begin n_fail++; $display("FAIL pp_first_pc got %h exp 100", iq_pc); end
        n_checks++; if (iq_rd !== 5'd6 || iq_unit !== UNIT_ALU || iq_command !== 4'd4)
            begin n_fail++; $display("FAIL pp_first_fields got rd=%0d unit=%0d cmd=%0d exp 6 0 4", iq_rd, iq_unit, iq_command); end
        drive_op(32'h104, 5'd5); step();
        drive_op(32'h108, 5'd6); step();
        dec_e_ = 1'b1;
        n_checks++; if (count !== 4'd3) begin n_fail++; $display("FAIL pp_count got %0d exp 3", count); end
        n_checks++; if (iq_pc !== 32'h100) begin n_fail++; $display("FAIL pp_hold_pc got %h exp 100", iq_pc); end
        issue_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (iq_pc !== 32'h100 + 32'(4 * i))
                begin n_fail++; $display("FAIL pp_order[%0d] got %h exp %h", i, iq_pc, 32'h100 + 32'(4 * i)); end
            step();
        end
        n_checks++; if (iq_e_ !== 1'b1 || count !== 4'd0)
            begin n_fail++; $display("FAIL pp_drained got iq_e_=%b count=%0d exp 1 0", iq_e_, count); end
        step();  // issue_ready held while empty must not underflow
        n_checks++; if (count !== 4'd0 || iq_pc !== 32'h0)
            begin n_fail++; $display("FAIL pp_underflow got count=%0d pc=%h exp 0 0", count, iq_pc); end
        issue_ready = 1'b0;
    endtask

    task automatic test_fill_overflow();
        issue_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_op(32'h300 + 32'(4 * i), 5'(i));
            step();
            if (i == 4) begin
                n_checks++; if (is_full !== 1'b0) begin n_fail++; $display("FAIL fill_is_full_at5 got %b exp 0", is_full); end
            end
            if (i == 5) begin
                n_checks++; if (is_full !== 1'b1 || count !== 4'd6)
                    begin n_fail++; $display("FAIL fill_is_full_at6 got %b count=%0d exp 1 6", is_full, count); end
            end
        end
        n_checks++; if (count !== 4'd8 || overflow !== 1'b1)
            begin n_fail++; $display("FAIL fill_full got count=%0d ovf=%b exp 8 1", count, overflow); end
        // Push while full with a simultaneous pop: push still dropped.
        drive_op(32'h3F0, 5'd30);
        issue_ready = 1'b1;
        step();
        dec_e_ = 1'b1;
        n_checks++; if (count !== 4'd7 || iq_pc !== 32'h304)
            begin n_fail++; $display("FAIL fill_push_pop_full got count=%0d pc=%h exp 7 304", count, iq_pc); end
        for (int i = 1; i < 8; i++) begin
            n_checks++; if (iq_pc !== 32'h300 + 32'(4 * i) || iq_rs1 !== 5'(i))
                begin n_fail++; $display("FAIL fill_drain[%0d] got pc=%h rs1=%0d exp %h %0d", i, iq_pc, iq_rs1, 32'h300 + 32'(4 * i), i); end
            step();
        end
        n_checks++; if (iq_e_ !== 1'b1 || count !== 4'd0 || overflow !== 1'b1)
            begin n_fail++; $display("FAIL fill_end got iq_e_=%b count=%0d ovf=%b exp 1 0 1", iq_e_, count, overflow); end
        issue_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h400 + 32'(4 * i), 5'(i + 8));
            step();
        end
        issue_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_op(32'h400 + 32'(4 * (k + 4)), 5'(k + 12));
            n_checks++; if (iq_pc !== 32'h400 + 32'(4 * k))
                begin n_fail++; $display("FAIL b2b_order[%0d] got %h exp %h", k, iq_pc, 32'h400 + 32'(4 * k)); end
            step();
            n_checks++; if (count !== 4'd4)
                begin n_fail++; $display("FAIL b2b_count[%0d] got %0d exp 4", k, count); end
        end
        dec_e_ = 1'b1; issue_ready = 1'b0;
    endtask

    task automatic test_flush();
        drive_op(32'h500, 5'd1);
        step();
        n_checks++; if (count !== 4'd5) begin n_fail++; $display("FAIL flush_pre_count got %0d exp 5", count); end
        flush = 1'b1; issue_ready = 1'b1;
        drive_op(32'h504, 5'd2);
        step();
        flush = 1'b0; dec_e_ = 1'b1; issue_ready = 1'b0;
        n_checks++; if (count !== 4'd0 || iq_e_ !== 1'b1 || overflow !== 1'b0 || iq_pc !== 32'h0)
            begin n_fail++; $display("FAIL flush_state got count=%0d iq_e_=%b ovf=%b pc=%h exp 0 1 0 0", count, iq_e_, overflow, iq_pc); end
        step();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_discard got %0d exp 0", count); end
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        drive_op(32'h200, 5'd9);
        #1;
`ifdef DEC_QUEUE_BYPASS_EN
        n_checks++; if (iq_e_ !== 1'b0 || iq_pc !== 32'h200)
            begin n_fail++; $display("FAIL byp_same_cycle got iq_e_=%b pc=%h exp 0 200", iq_e_, iq_pc); end
        step();
        dec_e_ = 1'b1;
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL byp_count got %0d exp 0", count); end
`else
        n_checks++; if (iq_e_ !== 1'b1) begin n_fail++; $display("FAIL nobyp_same_cycle got %b exp 1", iq_e_); end
        step();
        dec_e_ = 1'b1;
        n_checks++; if (count !== 4'd1 || iq_pc !== 32'h200)
            begin n_fail++; $display("FAIL nobyp_next got count=%0d pc=%h exp 1 200", count, iq_pc); end
        step();
        n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL nobyp_pop got %0d exp 0", count); end
`endif
        issue_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_fill_overflow();
        test_back_to_back();
        test_flush();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
